// File: rtl/bfp_pkg.sv
// Shared FP32 field layout and bank state type
// for the BFP group collector.
package bfp_pkg;

  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_W        = 1 + FP_EXP_W + FP_MAN_W;
  localparam int FP_EXP_LSB  = FP_MAN_W;
  localparam int FP_SIGN_BIT = FP_W - 1;

  localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = '1;

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL
  } bank_state_e;

endpackage

// File: rtl/bfp_grp_bank.sv
// One ping-pong bank: lane storage, close/free control,
// lane count, saturation flag and masked lane read-out.
//   clk, rst           clock, async active-high reset
//   wr_en/wr_idx       write one lane (exp, {sign,man})
//   close/close_cnt    seal the group with close_cnt real lanes
//   free               group consumed, bank returns to FREE
//   state              bank state
//   rd_exps/rd_mans    lanes, zeroed beyond count
//   count, sat         real lane count, any exp all-ones
module bfp_grp_bank
  import bfp_pkg::*;
#(
  parameter int GRPSIZE = 16,
  parameter int EXPW    = 8,
  parameter int MANW    = 24,
  parameter int IDXW    = $clog2(GRPSIZE),
  parameter int CNTW    = $clog2(GRPSIZE + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [IDXW-1:0]               wr_idx,
  input  logic [EXPW-1:0]               wr_exp,
  input  logic [MANW-1:0]               wr_man,
  input  logic                          close,
  input  logic [CNTW-1:0]               close_cnt,
  input  logic                          free,
  output bank_state_e                   state,
  output logic [GRPSIZE-1:0][EXPW-1:0]  rd_exps,
  output logic [GRPSIZE-1:0][MANW-1:0]  rd_mans,
  output logic [CNTW-1:0]               count,
  output logic                          sat
);

  bank_state_e                   state_q, state_d;
  logic [GRPSIZE-1:0][EXPW-1:0]  exps_q;
  logic [GRPSIZE-1:0][MANW-1:0]  mans_q;
  logic [GRPSIZE-1:0]            mask_q;
  logic [GRPSIZE-1:0]            close_mask;
  logic [CNTW-1:0]               count_q;
  logic                          sat_run_q;
  logic                          sat_q;
  logic                          sat_now;

  // The first lane of a group restarts the running flag.
  assign sat_now = ((state_q == BANK_FREE) ? 1'b0 : sat_run_q)
                 | (wr_exp == EXPW'(FP_EXP_ONES));

  always_comb begin
    close_mask = '0;
    for (int i = 0; i < GRPSIZE; i++) begin
      close_mask[i] = (i < int'(close_cnt));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      free:  state_d = BANK_FREE;
      close: state_d = BANK_FULL;
      (wr_en && state_q == BANK_FREE && !close):
             state_d = BANK_FILLING;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BANK_FREE;
      exps_q    <= '0;
      mans_q    <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      sat_run_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (wr_en) begin
        exps_q[wr_idx] <= wr_exp;
        mans_q[wr_idx] <= wr_man;
        sat_run_q      <= sat_now;
      end
      if (close) begin
        count_q <= close_cnt;
        mask_q  <= close_mask;
        sat_q   <= sat_now;
      end else if (free) begin
        count_q <= '0;
        mask_q  <= '0;
        sat_q   <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_exps = '0;
    rd_mans = '0;
    for (int i = 0; i < GRPSIZE; i++) begin
      rd_exps[i] = mask_q[i] ? exps_q[i] : '0;
      rd_mans[i] = mask_q[i] ? mans_q[i] : '0;
    end
  end

  assign state = state_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/bfp_group_collector.sv
// Gathers FP32 words into GRPSIZE-lane exponent/mantissa
// groups using two ping-pong banks.
//   i_clk, i_rst        clock, async active-high reset
//   i_valid/o_ready     word input handshake (i_data, i_last)
//   o_valid/i_ready     group output handshake
//   o_exps, o_mans      per-lane exponent and {sign,mantissa}
//   o_count, o_exp_sat  real lanes, any Inf/NaN lane
module bfp_group_collector
  import bfp_pkg::*;
#(
  parameter int GRPSIZE   = 16,
  parameter int FPEXPSIZE = FP_EXP_W,
  parameter int FPMANSIZE = FP_MAN_W
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic [FPEXPSIZE+FPMANSIZE:0]         i_data,
  input  logic                                 i_last,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [GRPSIZE-1:0][FPEXPSIZE-1:0]    o_exps,
  output logic [GRPSIZE-1:0][FPMANSIZE:0]      o_mans,
  output logic [$clog2(GRPSIZE+1)-1:0]         o_count,
  output logic                                 o_exp_sat
);

  localparam int IDXW = $clog2(GRPSIZE);
  localparam int CNTW = $clog2(GRPSIZE + 1);
  localparam int MANW = FPMANSIZE + 1;

  logic                         wr_sel;
  logic                         rd_sel;
  logic [IDXW-1:0]              wr_idx;
  logic                         acc;
  logic                         close;
  logic                         take;
  logic [CNTW-1:0]              close_cnt;
  logic [FPEXPSIZE-1:0]         exp_in;
  logic [MANW-1:0]              man_in;

  bank_state_e                  st     [2];
  logic [GRPSIZE-1:0][FPEXPSIZE-1:0] exps_b [2];
  logic [GRPSIZE-1:0][MANW-1:0] mans_b [2];
  logic [CNTW-1:0]              cnt_b  [2];
  logic                         sat_b  [2];

  assign exp_in = i_data[FPMANSIZE +: FPEXPSIZE];
  assign man_in = {i_data[FPEXPSIZE+FPMANSIZE],
                   i_data[FPMANSIZE-1:0]};

  // Both handshake outputs come from bank state only.
  assign o_ready = (st[wr_sel] != BANK_FULL);
  assign o_valid = (st[rd_sel] == BANK_FULL);

  assign acc   = i_valid && o_ready;
  assign take  = o_valid && i_ready;
  assign close = acc && (i_last
               || wr_idx == IDXW'(GRPSIZE - 1));
  assign close_cnt = CNTW'(wr_idx) + CNTW'(1);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bfp_grp_bank #(
      .GRPSIZE (GRPSIZE),
      .EXPW    (FPEXPSIZE),
      .MANW    (MANW)
    ) u_bank (
      .clk       (i_clk),
      .rst       (i_rst),
      .wr_en     (acc && (wr_sel == 1'(b))),
      .wr_idx    (wr_idx),
      .wr_exp    (exp_in),
      .wr_man    (man_in),
      .close     (close && (wr_sel == 1'(b))),
      .close_cnt (close_cnt),
      .free      (take && (rd_sel == 1'(b))),
      .state     (st[b]),
      .rd_exps   (exps_b[b]),
      .rd_mans   (mans_b[b]),
      .count     (cnt_b[b]),
      .sat       (sat_b[b])
    );
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (close) begin
        wr_idx <= '0;
        wr_sel <= ~wr_sel;
      end else if (acc) begin
        wr_idx <= wr_idx + IDXW'(1);
      end
      if (take) begin
        rd_sel <= ~rd_sel;
      end
    end
  end

  assign o_exps    = rd_sel ? exps_b[1] : exps_b[0];
  assign o_mans    = rd_sel ? mans_b[1] : mans_b[0];
  assign o_count   = rd_sel ? cnt_b[1]  : cnt_b[0];
  assign o_exp_sat = rd_sel ? sat_b[1]  : sat_b[0];

endmodule

// File: tb/tb_bfp_group_collector.sv
// Self-checking bench for bfp_group_collector: group model
// plus directed literal checks and a random stream.
module tb_bfp_group_collector;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic                 i_valid = 1'b0;
  logic                 o_ready;
  logic [31:0]          i_data = '0;
  logic                 i_last = 1'b0;
  logic                 o_valid;
  logic                 i_ready = 1'b0;
  logic [15:0][7:0]     o_exps;
  logic [15:0][23:0]    o_mans;
  logic [4:0]           o_count;
  logic                 o_exp_sat;

  int checks = 0;
  int errors = 0;
  int taken  = 0;

  logic [31:0] exp_words [$];
  int          grp_cnt   [$];
  logic [31:0] cur       [$];

  bfp_group_collector #(
    .GRPSIZE(16), .FPEXPSIZE(8), .FPMANSIZE(23)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_last(i_last),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_exps(o_exps), .o_mans(o_mans),
    .o_count(o_count), .o_exp_sat(o_exp_sat)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, want);
    end
  endtask

  // Model: groups are formed from accepted words and
  // consumed in order by takes.
  initial forever begin
    @(posedge i_clk or posedge i_rst);
    if (i_rst) begin
      exp_words.delete();
      grp_cnt.delete();
      cur.delete();
    end else begin
      if (o_valid && i_ready && grp_cnt.size() > 0) begin
        int n;
        n = grp_cnt.pop_front();
        for (int k = 0; k < n; k++) void'(exp_words.pop_front());
        taken += n;
      end
      if (i_valid && o_ready) begin
        cur.push_back(i_data);
        if (cur.size() == 16 || i_last) begin
          foreach (cur[k]) exp_words.push_back(cur[k]);
          grp_cnt.push_back(cur.size());
          cur.delete();
        end
      end
    end
  end

  // Compare DUT outputs to the model every cycle.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst) begin
      int pend;
      pend = grp_cnt.size();
      check("o_valid", 32'(o_valid), 32'(pend > 0));
      check("o_ready", 32'(o_ready), 32'(pend < 2));
      if (pend > 0) begin
        int n;
        logic s;
        logic [31:0] w;
        logic [7:0] e;
        logic [23:0] m;
        n = grp_cnt[0];
        s = 1'b0;
        check("o_count", 32'(o_count), 32'(n));
        for (int i = 0; i < 16; i++) begin
          e = '0;
          m = '0;
          if (i < n) begin
            w = exp_words[i];
            e = w[30:23];
            m = {w[31], w[22:0]};
            s = s | (e == 8'hFF);
          end
          check($sformatf("exp[%0d]", i), 32'(o_exps[i]), 32'(e));
          check($sformatf("man[%0d]", i), 32'(o_mans[i]), 32'(m));
        end
        check("o_exp_sat", 32'(o_exp_sat), 32'(s));
      end
    end
  end

  task automatic drive(input logic [31:0] w, input logic last);
    bit ok;
    ok = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b1;
    i_data  = w;
    i_last  = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (o_ready) ok = 1'b1;
      @(posedge i_clk);
      if (!ok) @(negedge i_clk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
    end
  endtask

  task automatic drain();
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    for (int t = 0; t < 50 && grp_cnt.size() > 0; t++) begin
      @(negedge i_clk);
    end
    check("drain_empty", 32'(grp_cnt.size()), 32'd0);
    i_ready = 1'b0;
  endtask

  function automatic logic [31:0] fp_int(input int v);
    // Exact FP32 encoding of small positive integers.
    int p;
    logic [31:0] r;
    p = 0;
    while ((v >> (p + 1)) != 0) p++;
    r = '0;
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((v - (1 << p)) << (23 - p));
    return r;
  endfunction

  initial begin
    int na;
    bit a;
    // Reset state
    repeat (3) @(negedge i_clk);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_ready", 32'(o_ready), 32'd1);
    check("rst_o_count", 32'(o_count), 32'd0);
    check("rst_o_exps", 32'(o_exps[0]), 32'd0);
    i_rst = 1'b0;

    // 1: 1.0f..16.0f back to back
    i_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      drive(fp_int(k), 1'b0);
      check("t1_ready", 32'(o_ready || k == 16), 32'd1);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_count", 32'(o_count), 32'd16);
    check("t1_exp0", 32'(o_exps[0]), 32'd127);
    check("t1_man0", 32'(o_mans[0]), 32'd0);
    check("t1_man2", 32'(o_mans[2]), 32'h400000);
    check("t1_exp15", 32'(o_exps[15]), 32'd131);
    check("t1_ready1", 32'(o_ready), 32'd1);
    drain();

    // 2: backpressure, 40 words offered
    na = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = {1'b0, 8'(k + 1), 23'(k * 3)};
      a = o_ready;
      @(posedge i_clk);
      if (a) na++;
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    check("t2_accepted", 32'(na), 32'd32);
    check("t2_ready0", 32'(o_ready), 32'd0);
    check("t2_valid", 32'(o_valid), 32'd1);
    check("t2_exp0", 32'(o_exps[0]), 32'd1);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("t2_ready1", 32'(o_ready), 32'd1);
    check("t2_valid2", 32'(o_valid), 32'd1);
    check("t2_exp0b", 32'(o_exps[0]), 32'd17);
    drain();

    // 3: partial group of five
    for (int k = 1; k <= 5; k++) drive(fp_int(k), k == 5);
    drive(fp_int(9), 1'b1);
    idle(1);
    check("t3_count", 32'(o_count), 32'd5);
    check("t3_exp4", 32'(o_exps[4]), 32'd129);
    check("t3_exp5", 32'(o_exps[5]), 32'd0);
    check("t3_man5", 32'(o_mans[5]), 32'd0);
    check("t3_exp15", 32'(o_exps[15]), 32'd0);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("t3_next_count", 32'(o_count), 32'd1);
    check("t3_next_exp0", 32'(o_exps[0]), 32'd130);
    check("t3_next_man0", 32'(o_mans[0]), 32'h100000);
    drain();

    // 4: -Inf in lane 3, i_last on lane 15
    for (int k = 0; k < 16; k++)
      drive((k == 3) ? 32'hFF800000 : fp_int(1), k == 15);
    for (int k = 0; k < 4; k++) drive(fp_int(2), k == 3);
    idle(1);
    check("t4_sat", 32'(o_exp_sat), 32'd1);
    check("t4_count", 32'(o_count), 32'd16);
    check("t4_exp3", 32'(o_exps[3]), 32'hFF);
    check("t4_man3", 32'(o_mans[3]), 32'h800000);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    check("t4_sat2", 32'(o_exp_sat), 32'd0);
    check("t4_count2", 32'(o_count), 32'd4);
    drain();

    // 5: reset with one group waiting, one part-filled
    for (int k = 0; k < 23; k++) drive(fp_int(3), 1'b0);
    idle(1);
    check("t5_pre_ready", 32'(o_ready), 32'd1);
    i_rst = 1'b1;
    #1;
    check("t5_valid", 32'(o_valid), 32'd0);
    check("t5_ready", 32'(o_ready), 32'd1);
    check("t5_count", 32'(o_count), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    drive(fp_int(1), 1'b1);
    idle(1);
    check("t5_post_count", 32'(o_count), 32'd1);
    check("t5_post_exp0", 32'(o_exps[0]), 32'd127);
    drain();

    // 6: random handshakes, 1000 words
    taken = 0;
    na = 0;
    for (int c = 0; c < 20000 && taken < 1000; c++) begin
      @(negedge i_clk);
      i_valid = (na < 1000) && ($urandom_range(9) < 7);
      i_ready = ($urandom_range(9) < 6);
      i_data  = $urandom;
      i_last  = ($urandom_range(5) == 0) || (na == 999);
      a = i_valid && o_ready;
      @(posedge i_clk);
      if (a) na++;
    end
    check("t6_sent", 32'(na), 32'd1000);
    check("t6_taken", 32'(taken), 32'd1000);
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
